// File: rtl/shift_right_seq_if.sv
// rtl/shift_right_seq_if.sv - operand/result/handshake bundle for the sequential right shifter
interface shift_right_seq_if;
    logic [7:0] sumrest;
    logic [2:0] MovR;
    logic       arith;
    logic       start;
    logic [7:0] Shift_Right;
    logic       Carry;
    logic       busy;
    logic       done;

    // Requester side: supplies operands and start, observes result and status
    modport master (
        output sumrest,
        output MovR,
        output arith,
        output start,
        input  Shift_Right,
        input  Carry,
        input  busy,
        input  done
    );

    // Shifter side
    modport slave (
        input  sumrest,
        input  MovR,
        input  arith,
        input  start,
        output Shift_Right,
        output Carry,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_right_seq.sv
// rtl/shift_right_seq.sv - 8-bit right shifter, one bit per clock, start/busy/done handshake (arith fill under SHIFT_RIGHT_ARITH_EN)
module shift_right_seq (
    input  logic               clk,
    input  logic               rst,
    shift_right_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] wr;
    logic [2:0] cnt;
    logic       af;
    logic       cy;
    logic [7:0] result;
    logic       carry_q;
    logic       busy_q;
    logic       done_q;
    logic       arith_sel;
    logic       fill;

    // With the arithmetic option compiled out every shift zero-fills
`ifdef SHIFT_RIGHT_ARITH_EN
    assign arith_sel = bus.arith;
`else
    assign arith_sel = 1'b0;
`endif

    assign fill = af & wr[7];

    assign bus.Shift_Right = result;
    assign bus.Carry       = carry_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

    // Control FSM with datapath; busy/done registered alongside the state they decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr      <= 8'h00;
            cnt     <= 3'd0;
            af      <= 1'b0;
            cy      <= 1'b0;
            result  <= 8'h00;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        wr     <= bus.sumrest;
                        cnt    <= bus.MovR;
                        af     <= arith_sel;
                        cy     <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= LOAD;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                LOAD: begin
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == 3'd0) begin
                        result  <= wr;
                        carry_q <= cy;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cy     <= wr[0];
                        wr     <= {fill, wr[7:1]};
                        cnt    <= cnt - 3'd1;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        state  <= SHIFT;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/shift_right_seq.md
# shift_right_seq

Sequential 8-bit right shifter for the 8-bit ALU. It is the right-direction counterpart of the combinational left-shift path. It takes the adder/subtractor result `sumrest` and shifts it right by `MovR` positions, one bit per clock, under a start/busy/done handshake. The result is held on `Shift_Right` until the next operation completes, so the ALU output mux can sample it at leisure.

## Interface
- No parameters; the width is fixed at 8 bits and the shift amount at 3 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sumrest`  in  8  operand; sampled only on an accepted `start`.
- `MovR`  in  3  shift amount 0..7; sampled only on an accepted `start`.
- `arith`  in  1  1 = arithmetic fill (copy of bit 7), 0 = logical fill (0); sampled on an accepted `start`.
- `start`  in  1  request; accepted when the state is IDLE or DONE.
- `Shift_Right`  out  8  registered result.
- `Carry`  out  1  last bit shifted out; 0 when `MovR` = 0.
- `busy`  out  1  high while in LOAD or SHIFT.
- `done`  out  1  one-cycle pulse; high only in the DONE state.

## Operation
- State register: IDLE, LOAD, SHIFT, DONE. Internal registers: 8-bit working register `wr`, 3-bit count `cnt`, fill flag `af`, carry `cy`.
- IDLE or DONE with `start`=1:
  - `wr`←`sumrest`, `cnt`←`MovR`, `af`←`arith`, `cy`←0.
  - Go to LOAD.
- IDLE or DONE with `start`=0: go to IDLE. DONE therefore lasts exactly 1 cycle.
- LOAD: go to SHIFT unconditionally. This state is the 1-cycle operand capture slot.
- SHIFT with `cnt`=0:
  - `Shift_Right`←`wr`, `Carry`←`cy`.
  - Go to DONE.
- SHIFT with `cnt`≠0:
  - `cy`←`wr[0]`.
  - `wr`←{fill, `wr[7:1]`}, where fill = `af` ? `wr[7]` : 0.
  - `cnt`←`cnt`−1.
  - Stay in SHIFT.
- `start` in LOAD or SHIFT is ignored; the operation in flight is neither restarted nor corrupted.
- `Shift_Right` and `Carry` change only on the SHIFT→DONE transition. Otherwise they hold the previous result.
- The result equals `sumrest >> MovR` (logical) or `$signed(sumrest) >>> MovR` (arithmetic), truncated to 8 bits.

## Timing
- Reset (asynchronous, any state, including mid-shift):
  - State = IDLE.
  - `Shift_Right`=8'h00, `Carry`=0, `busy`=0, `done`=0.
  - `wr`, `cnt`, `af` and `cy` are cleared to 0.
- Let `start` be sampled at edge E. Then:
  - `busy` is high from after edge E through edge E+`MovR`+2.
  - `done` and the new `Shift_Right`/`Carry` are visible after edge E+`MovR`+2.
  - Start-to-done latency is therefore `MovR`+2 cycles: 2 cycles for `MovR`=0, 9 cycles for `MovR`=7.
- Back-to-back operation: `start` held high during the DONE cycle launches the next operation. Throughput is one result per `MovR`+3 cycles.
- `busy` and `done` are never high together.
- All outputs are registered or decoded directly from the state register; there is no combinational path from inputs to outputs.

## Configuration
- `SHIFT_RIGHT_ARITH_EN` defined: the `arith` input is honoured as described above.
- `SHIFT_RIGHT_ARITH_EN` undefined: the `arith` port remains but is ignored. `af` is tied to 0, so every shift is logical and zero-fills. Timing is unchanged.

## Test plan
- Logical shift: `sumrest`=8'hB4, `MovR`=3, `arith`=0, one-cycle `start` → `done` 5 cycles later, `Shift_Right`=8'h16, `Carry`=1.
- Arithmetic shift: same stimulus with `arith`=1 → `Shift_Right`=8'hF6, `Carry`=1. With the macro undefined → 8'h16.
- Zero shift: `sumrest`=8'h5A, `MovR`=0 → `done` 2 cycles after `start`, `Shift_Right`=8'h5A, `Carry`=0, `busy` high for exactly 2 cycles.
- Maximum shift:
  - `sumrest`=8'h81, `MovR`=7, logical → 8'h01, `Carry`=0, latency 9 cycles.
  - Same with `arith`=1 → 8'hFF.
- Handshake:
  - `start` pulsed again while `busy` with a different operand → ignored, first result unaffected.
  - `start` held through DONE → second operation begins with no idle cycle.
- Reset mid-operation: assert `rst` asynchronously during SHIFT of 8'hB4>>3 → outputs are 0 immediately and the state is IDLE. The next `start` with 8'hF0>>4 gives 8'h0F, `Carry`=0.
